// File: rtl/ddr_arbiter_mister_pkg.sv
// ddr_arb_pkg: shared types and widths for the MiSTer DDRAM arbiter.
package ddr_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} arb_state_t;
   localparam int DDR_AW  = 29;
   localparam int DDR_DW  = 64;
   localparam int DDR_BEW = 8;
endpackage

// File: rtl/ddr_arbiter_mister_if.sv
// ddr_arbiter_mister_if: requester ports plus the DDRAM Avalon-MM pins.
// slave = arbiter view, master = requesters/DDR side view.
interface ddr_arbiter_mister_if;
   import ddr_arb_pkg::*;
   logic [1:0]         rq_req;
   logic [1:0]         rq_write;
   logic [DDR_AW-1:0]  rq_addr0;
   logic [DDR_AW-1:0]  rq_addr1;
   logic [DDR_DW-1:0]  rq_wdata0;
   logic [DDR_DW-1:0]  rq_wdata1;
   logic [DDR_BEW-1:0] rq_be0;
   logic [DDR_BEW-1:0] rq_be1;
   logic [1:0]         rq_ack;
   logic [DDR_DW-1:0]  rq_rdata;
   logic               DDRAM_BUSY;
   logic [7:0]         DDRAM_BURSTCNT;
   logic [DDR_AW-1:0]  DDRAM_ADDR;
   logic [DDR_DW-1:0]  DDRAM_DOUT;
   logic               DDRAM_DOUT_READY;
   logic               DDRAM_RD;
   logic [DDR_DW-1:0]  DDRAM_DIN;
   logic [DDR_BEW-1:0] DDRAM_BE;
   logic               DDRAM_WE;
   modport slave (
      input  rq_req, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_be0, rq_be1,
      input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      output rq_ack, rq_rdata,
      output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
   );
   modport master (
      output rq_req, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_be0, rq_be1,
      output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      input  rq_ack, rq_rdata,
      input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
   );
endinterface

// File: rtl/ddr_arbiter_mister_rr.sv
// ddr_arb_rr: 2-way round-robin picker; a lone requester always wins,
// a tie goes to the port that did not win last.
module ddr_arb_rr (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);
   always_comb begin
      grant       = (req == 2'b10) | ((req == 2'b11) & ~last_grant);
      grant_valid = |req;
   end
endmodule

// File: rtl/ddr_arbiter_mister.sv
// ddr_arbiter_mister: shares the MiSTer DDRAM master between two requesters,
// one burst-1 transaction at a time. Read watchdog enabled by DDR_ARB_TIMEOUT_EN.
module ddr_arbiter_mister
   import ddr_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ddr_arbiter_mister_if.slave  bus,
   output logic                 busy,
   output logic                 timeout_err
);
   arb_state_t         state_q, state_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic [DDR_AW-1:0]  addr_q, addr_d;
   logic [DDR_DW-1:0]  wdata_q, wdata_d;
   logic [DDR_BEW-1:0] be_q, be_d;
   logic               wr_q, wr_d;
   logic [DDR_DW-1:0]  rdata_q, rdata_d;
   logic               rr_grant, rr_valid;
   logic               cmd_on;
`ifdef DDR_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        terr_q, terr_d;
`endif

   ddr_arb_rr u_rr (
      .req         (bus.rq_req),
      .last_grant  (last_grant_q),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      wr_d         = wr_q;
      rdata_d      = rdata_q;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      terr_d       = terr_q;
`endif
      case (state_q)
         IDLE: if (rr_valid) begin
            grant_d      = rr_grant;
            last_grant_d = rr_grant;
            addr_d       = rr_grant ? bus.rq_addr1  : bus.rq_addr0;
            wdata_d      = rr_grant ? bus.rq_wdata1 : bus.rq_wdata0;
            be_d         = rr_grant ? bus.rq_be1    : bus.rq_be0;
            wr_d         = bus.rq_write[rr_grant];
            state_d      = ISSUE;
         end
         ISSUE: begin
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (!bus.DDRAM_BUSY) state_d = wr_q ? ACK : RDWAIT;
         end
         RDWAIT: if (bus.DDRAM_DOUT_READY) begin
            rdata_d = bus.DDRAM_DOUT;
            state_d = ACK;
         end
`ifdef DDR_ARB_TIMEOUT_EN
         else if (cnt_q == TO_LAST) begin
            rdata_d = '1;
            terr_d  = 1'b1;
            state_d = ACK;
         end else cnt_d = cnt_q + 16'd1;
`endif
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         wr_q         <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         wr_q         <= wr_d;
         rdata_q      <= rdata_d;
      end
   end

`ifdef DDR_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

   // commands are gated by reset so they fall the moment reset is asserted
   assign cmd_on             = reset_n && state_q == ISSUE;
   assign bus.DDRAM_RD       = cmd_on & ~wr_q;
   assign bus.DDRAM_WE       = cmd_on & wr_q;
   assign bus.DDRAM_BURSTCNT = 8'd1;
   assign bus.DDRAM_ADDR     = addr_q;
   assign bus.DDRAM_DIN      = wdata_q;
   assign bus.DDRAM_BE       = be_q;
   assign bus.rq_ack         = (state_q == ACK) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rq_rdata       = rdata_q;
   assign busy               = state_q != IDLE;
endmodule

// File: tb/tb_ddr_arbiter_mister.sv
// tb_ddr_arbiter_mister: directed stimulus, queue scoreboard, behavioural DDR responder.
module tb_ddr_arbiter_mister;
   typedef struct { logic we; logic [28:0] addr; logic [63:0] din; logic [7:0] be; } cmd_t;
   typedef struct { logic [1:0] ack; logic rd; logic [63:0] rdata; } ack_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic busy, timeout_err;
   int   cyc = 0, checks = 0, passed = 0;
   int   stall_left = 0, resp_cnt = 0, resp_lat = 1, rd_run = 0, last_rd_run = 0;
   int   cmd_cyc = 0, acks_seen = 0;
   logic resp_en = 1'b1, stray = 1'b0;
   logic [63:0] resp_data = '0, stray_data = '0;
   cmd_t cmd_q[$];
   ack_t ack_q[$];

   ddr_arbiter_mister_if m ();
   ddr_arbiter_mister #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (m.slave),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // DDR side: waitrequest stalls, then read data after resp_lat cycles
   always @(negedge clk) begin
      m.DDRAM_DOUT_READY = 1'b0;
      if (stray) begin
         m.DDRAM_DOUT_READY = 1'b1;
         m.DDRAM_DOUT = stray_data;
         stray = 1'b0;
      end
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            m.DDRAM_DOUT_READY = 1'b1;
            m.DDRAM_DOUT = resp_data;
         end
      end
      m.DDRAM_BUSY = (m.DDRAM_RD || m.DDRAM_WE) && stall_left > 0;
      if (m.DDRAM_BUSY) stall_left--;
      else if (m.DDRAM_RD && resp_en) resp_cnt = resp_lat;
   end

   always @(negedge clk) begin : mon
      cmd_t c;
      ack_t a;
      #1;
      if (m.DDRAM_RD) rd_run++;
      else rd_run = 0;
      if ((m.DDRAM_RD || m.DDRAM_WE) && !m.DDRAM_BUSY) begin
         if (cmd_q.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
         else begin
            c = cmd_q.pop_front();
            chk("cmd_we", 64'(m.DDRAM_WE), 64'(c.we));
            chk("cmd_rd", 64'(m.DDRAM_RD), 64'(!c.we));
            chk("cmd_addr", 64'(m.DDRAM_ADDR), 64'(c.addr));
            chk("cmd_be", 64'(m.DDRAM_BE), 64'(c.be));
            chk("cmd_burst", 64'(m.DDRAM_BURSTCNT), 64'd1);
            if (c.we) chk("cmd_din", m.DDRAM_DIN, c.din);
         end
         last_rd_run = rd_run;
         rd_run = 0;
         cmd_cyc = cyc;
      end
      if (m.rq_ack != 2'b00) begin
         acks_seen++;
         if (ack_q.size() == 0) chk("ack_unexpected", 64'(m.rq_ack), 64'd0);
         else begin
            a = ack_q.pop_front();
            chk("ack_port", 64'(m.rq_ack), 64'(a.ack));
            if (a.rd) chk("ack_rdata", m.rq_rdata, a.rdata);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic issue(input int p, input logic w, input logic [28:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic [63:0] rexp, input logic exp_ack);
      cmd_t c;
      ack_t k;
      if (p == 0) begin
         m.rq_addr0 = a; m.rq_wdata0 = d; m.rq_be0 = be;
      end else begin
         m.rq_addr1 = a; m.rq_wdata1 = d; m.rq_be1 = be;
      end
      m.rq_write[p] = w;
      c.we = w; c.addr = a; c.din = d; c.be = be;
      cmd_q.push_back(c);
      if (exp_ack) begin
         k.ack = (p == 0) ? 2'b01 : 2'b10; k.rd = !w; k.rdata = rexp;
         ack_q.push_back(k);
      end
      m.rq_req[p] = 1'b1;
   endtask

   task automatic wait_ack(input int p, output int at);
      at = -1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (m.rq_ack[p]) begin
            at = cyc;
            m.rq_req[p] = 1'b0;
            break;
         end
      end
      if (at < 0) chk("ack_wait_expired", 64'd0, 64'd1);
   endtask

   initial begin
      int t0, ta, base;
      m.rq_req = 2'b11; m.rq_write = 2'b00;
      m.rq_addr0 = '0; m.rq_addr1 = '0; m.rq_wdata0 = '0; m.rq_wdata1 = '0;
      m.rq_be0 = '0; m.rq_be1 = '0;
      m.DDRAM_BUSY = 1'b0; m.DDRAM_DOUT = '0; m.DDRAM_DOUT_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("reset_outs", {m.rq_ack, m.DDRAM_RD, m.DDRAM_WE, busy, timeout_err, m.rq_rdata != 64'd0},
             64'd0);
      end
      m.rq_req = 2'b00;
      reset_n = 1'b1;
      step(2);

      // single write, no waitrequest: ack two clocks after req
      issue(0, 1'b1, 29'h100, 64'hDEAD_BEEF_0123_4567, 8'hFF, '0, 1'b1);
      t0 = cyc;
      wait_ack(0, ta);
      chk("write_latency", 64'(ta - t0), 64'd2);
      step(2);

      // port1 read with 3 waitrequest clocks
      stall_left = 3; resp_lat = 2; resp_data = 64'h55AA;
      issue(1, 1'b0, 29'h1ABCDEF, '0, 8'h0F, 64'h55AA, 1'b1);
      t0 = cyc;
      wait_ack(1, ta);
      chk("rd_hold_cycles", 64'(last_rd_run), 64'd4);
      chk("read_latency", 64'(ta - t0), 64'd7);
      chk("rdata_held", m.rq_rdata, 64'h55AA);
      step(2);

      // reset while in RDWAIT; the late read return must be dropped
      resp_lat = 6; resp_data = 64'h1234;
      issue(0, 1'b0, 29'h200, '0, 8'hFF, '0, 1'b0);
      step(2);
      chk("in_rdwait", {62'd0, busy, m.DDRAM_RD}, 64'b10);
      reset_n = 1'b0;
      m.rq_req = 2'b00;
      step(2);
      reset_n = 1'b1;
      step(8);
      chk("orphan_rdata", m.rq_rdata, 64'd0);
      chk("orphan_idle", 64'(busy), 64'd0);

      // contention: both ports keep requesting, grants alternate starting at port 0
      m.rq_addr0 = 29'h10; m.rq_wdata0 = 64'hA0; m.rq_be0 = 8'hFF; m.rq_write[0] = 1'b1;
      m.rq_addr1 = 29'h11; m.rq_wdata1 = 64'hB1; m.rq_be1 = 8'h0F; m.rq_write[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_t c;
         ack_t k;
         c.we = 1'b1; c.addr = (i % 2) ? 29'h11 : 29'h10;
         c.din = (i % 2) ? 64'hB1 : 64'hA0; c.be = (i % 2) ? 8'h0F : 8'hFF;
         cmd_q.push_back(c);
         k.ack = (i % 2) ? 2'b10 : 2'b01; k.rd = 1'b0; k.rdata = '0;
         ack_q.push_back(k);
      end
      base = acks_seen;
      m.rq_req = 2'b11;
      for (int i = 0; i < 100 && acks_seen < base + 6; i++) step();
      m.rq_req = 2'b00;
      chk("contention_acks", 64'(acks_seen - base), 64'd6);
      step(2);

      // requester drops req mid-transaction; ack still pulses
      stall_left = 2;
      issue(1, 1'b1, 29'h333, 64'h0F0F, 8'h3C, '0, 1'b1);
      step(2);
      m.rq_req[1] = 1'b0;
      wait_ack(1, ta);
      step(2);

      // stray read data while idle is ignored
      resp_lat = 1; resp_data = 64'hCAFE;
      issue(1, 1'b0, 29'h444, '0, 8'hFF, 64'hCAFE, 1'b1);
      wait_ack(1, ta);
      step(2);
      stray_data = 64'hBAD; stray = 1'b1;
      step(3);
      chk("stray_ignored", m.rq_rdata, 64'hCAFE);

`ifdef DDR_ARB_TIMEOUT_EN
      resp_en = 1'b0;
      issue(0, 1'b0, 29'h555, '0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      wait_ack(0, ta);
      chk("timeout_rdwait_clks", 64'(ta - cmd_cyc), 64'd9);
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      step(4);
      chk("timeout_err_sticky", 64'(timeout_err), 64'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
      resp_en = 1'b1;
`else
      chk("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

      step(5);
      chk("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
      chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
